cam_st_capture: RTL
===================

CAM_ST_CAPTURE -- requirements
Module: cam_st_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 12, camera pixel and Avalon-ST symbol width (>=4).
REQ-002 SHALL have parameter FIFO_DEPTH, default 32, output FIFO entries (power of 2, >=16).
REQ-003 SHALL have parameter CNT_W, default 16, width of the dimension and statistics counters.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have ports:
  clk  in  1  sole clock; camera pins are synchronous to it.
  reset  in  1  synchronous, active-high.
  cam_d  in  DATA_W  pixel data.
  cam_fval  in  1  frame valid.
  cam_lval  in  1  line valid.
  capture_en  in  1  frame admission gate.
  st_data  out  DATA_W  Avalon-ST video data.
  st_valid, st_sop, st_eop  out  1 each  Avalon-ST qualifiers.
  st_ready  in  1  sink ready.
  frame_cnt, ovf_cnt, skip_cnt  out  CNT_W each  saturating statistics.
  last_width, last_height  out  CNT_W each  dimensions of the last completed frame.
  busy  out  1  high while in any state other than IDLE.

Function
REQ-006 SHALL register cam_d/fval/lval once; all edge detection uses the registered copies.
REQ-007 SHALL have states IDLE, CAPTURE, DROP and, with REQ-021, CTRL.
REQ-008 IDLE->CAPTURE on fval rise with capture_en=1; the header beat (data 0, sop=1) loads the hold register.
REQ-009 SHALL ignore fval rise with capture_en=0 and any frame already in progress at reset release; capture_en changes mid-frame have no effect.
REQ-010 SHALL treat a pixel as each registered cycle with fval&lval=1 in CAPTURE.
REQ-011 On each pixel, the held beat is written to the FIFO with eop=0 and the pixel replaces it in hold.
REQ-012 On fval fall in CAPTURE, the held beat is written with eop=1, frame_cnt increments, and the FSM goes to IDLE.
REQ-013 A frame with zero pixels SHALL emit one beat: data 0, sop=1, eop=1.
REQ-014 Overflow: if a pixel arrives while FIFO count >= FIFO_DEPTH-1, the held beat is written with eop=1, the pixel is discarded, ovf_cnt increments, and the FSM goes to DROP.
REQ-015 DROP SHALL discard all input until fval falls, then go to IDLE; frame_cnt does not increment.
REQ-016 A FIFO read (st_valid&st_ready) in the same cycle as a write SHALL be legal; the overflow test uses the pre-update count.
REQ-017 A beat written at edge N SHALL be visible on st_* no earlier than after edge N+1, in strict write order; st_* hold stable while st_valid&!st_ready.
REQ-018 last_width SHALL be the pixel count of the final line of a completed frame, and last_height the count of lval rises within fval; both update at fval fall of a completed frame only.
REQ-019 All counters SHALL saturate at 2^CNT_W-1.

Reset
REQ-020 On reset: state IDLE; FIFO empty; st_valid=0, st_sop=0, st_eop=0, st_data=0; all counters, last_width and last_height 0; busy=0. Reset mid-frame SHALL drop the partial frame without emitting an eop.

Configuration
REQ-021 With CAM_CTRL_PKT_EN defined, each completed frame SHALL be followed by a VIP control packet emitted from state CTRL:
  - 10 beats, one per cycle while the FIFO has space.
  - Beat 0 is 0xF with sop=1.
  - Beats 1-9 carry nibbles in data[3:0]: width[15:12..3:0], height[15:12..3:0], then 0x3 with eop=1.
  - Upper data bits are 0.
REQ-022 If fval rises while in CTRL, the packet SHALL complete, that frame is skipped, and skip_cnt increments.
REQ-023 Without CAM_CTRL_PKT_EN, no CTRL state exists and skip_cnt is tied to 0.

Structure
REQ-024 Package cam_cap_pkg SHALL hold the state enum, the FIFO beat struct {sop, eop, data}, the packet-type constants (video 0x0, control 0xF) and the interlace nibble 0x3.
REQ-025 Sub-module cam_cap_fifo SHALL implement the synchronous show-ahead FIFO with a count output.

Verification
REQ-026 4x3 frame, st_ready=1 -> 13 beats: header (sop, data 0), 12 pixels in order, eop on the last pixel; last_width=4, last_height=3, frame_cnt=1.
REQ-027 FIFO_DEPTH=16, st_ready=0, 2 lines of 20 pixels -> 16 beats buffered, the last with eop; ovf_cnt=1; the next 4x3 frame with st_ready=1 is correct.
REQ-028 fval high 5 cycles with no lval -> single beat with sop=1, eop=1, data 0.
REQ-029 capture_en=0 at fval rise, raised mid-frame -> no beats. Reset asserted during line 2 -> st_valid=0 next cycle and the following frame is captured intact.
REQ-030 CAM_CTRL_PKT_EN, 4x3 frame -> after the eop, beats 0xF,0,0,0,4,0,0,0,3,3 with eop on the last; fval rising 3 cycles after the frame -> skip_cnt=1.

Source files
------------

// File: rtl/cam_cap_pkg.sv
// cam_cap_pkg: shared FSM state enum, FIFO beat type and Avalon-ST video packet constants.
// Beat data is carried at BEAT_DATA_W bits and narrowed to DATA_W at the stream output.
package cam_cap_pkg;
  localparam int BEAT_DATA_W = 32;
  localparam logic [3:0] PKT_VIDEO = 4'h0;
  localparam logic [3:0] PKT_CTRL = 4'hF;
  localparam logic [3:0] INTERLACE_NIB = 4'h3;
`ifdef CAM_CTRL_PKT_EN
  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DROP, S_CTRL} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DROP} state_e;
`endif
  typedef struct packed {
    logic sop;
    logic eop;
    logic [BEAT_DATA_W-1:0] data;
  } beat_t;
endpackage

// File: rtl/cam_cap_fifo.sv
// cam_cap_fifo: synchronous show-ahead beat FIFO with a one-cycle write staging register.
// Ports: clk, reset, wr_i/wd_i write request, rd_ready_i pops the head when valid_o,
// rd_o head beat (zero when empty), cnt_o occupancy including the staged write.
module cam_cap_fifo
  import cam_cap_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_i,
  input  beat_t       wd_i,
  input  logic        rd_ready_i,
  output logic        valid_o,
  output beat_t       rd_o,
  output logic [AW:0] cnt_o
);
  logic wr_q, push, pop;
  beat_t wd_q;
  beat_t mem [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] used_q;
  assign valid_o = used_q != '0;
  assign pop = valid_o & rd_ready_i;
  assign push = wr_q & ((used_q != (AW+1)'(DEPTH)) | pop);
  assign rd_o = valid_o ? mem[rp_q] : '0;
  // the staged write is already committed, so it counts toward occupancy
  assign cnt_o = used_q + (AW+1)'(wr_q);
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= 1'b0;
      wd_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      used_q <= '0;
    end else begin
      wr_q <= wr_i;
      wd_q <= wd_i;
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      used_q <= used_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= wd_q;
  end
endmodule

// File: rtl/cam_st_capture.sv
// cam_st_capture: parallel camera (fval/lval) to Avalon-ST video frame capture with statistics.
// Ports: clk, reset (sync, active-high), cam_d/cam_fval/cam_lval camera pins, capture_en gate,
// st_data/st_valid/st_sop/st_eop/st_ready stream, frame_cnt/ovf_cnt/skip_cnt statistics,
// last_width/last_height of the last completed frame, busy when not IDLE.
// Define CAM_CTRL_PKT_EN to follow each completed frame with a VIP control packet.
module cam_st_capture
  import cam_cap_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] cam_d,
  input  logic              cam_fval,
  input  logic              cam_lval,
  input  logic              capture_en,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  output logic              st_sop,
  output logic              st_eop,
  input  logic              st_ready,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  ovf_cnt,
  output logic [CNT_W-1:0]  skip_cnt,
  output logic [CNT_W-1:0]  last_width,
  output logic [CNT_W-1:0]  last_height,
  output logic              busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
  logic [DATA_W-1:0] d_q;
  logic fval_q, fval_p_q, lval_q, lval_p_q;
  logic fval_rise, fval_fall, pixel, lval_rise, ovf, space;
  state_e state_q, state_d;
  beat_t hold_q, hold_d, wbeat, rd_beat;
  logic wr, frame_inc, ovf_inc, dims_upd;
  logic [AW:0] fifo_cnt;
  logic [CNT_W-1:0] frame_q, ovf_q, lw_q, lh_q, cw_q, ch_q;
  assign fval_rise = fval_q & ~fval_p_q;
  assign fval_fall = ~fval_q & fval_p_q;
  assign pixel = fval_q & lval_q;
  assign lval_rise = pixel & ~lval_p_q;
  assign ovf = fifo_cnt >= (AW+1)'(FIFO_DEPTH - 1);
  assign space = fifo_cnt < (AW+1)'(FIFO_DEPTH);
`ifdef CAM_CTRL_PKT_EN
  logic [3:0] idx_q, idx_d, nib;
  logic [15:0] w16, h16;
  logic skip_inc;
  logic [CNT_W-1:0] skip_q;
  assign w16 = 16'(lw_q);
  assign h16 = 16'(lh_q);
  // beats 1..8 walk {width, height} from the top nibble down
  assign nib = idx_q == 4'd0 ? PKT_CTRL : idx_q == 4'd9 ? INTERLACE_NIB :
               4'({w16, h16} >> (6'd32 - {idx_q, 2'b00}));
  assign skip_cnt = skip_q;
`else
  assign skip_cnt = '0;
`endif
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    wr = 1'b0;
    wbeat = hold_q;
    frame_inc = 1'b0;
    ovf_inc = 1'b0;
    dims_upd = 1'b0;
`ifdef CAM_CTRL_PKT_EN
    idx_d = idx_q;
    skip_inc = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (fval_rise && capture_en) begin
          state_d = S_CAPTURE;
          hold_d = '{sop: 1'b1, eop: 1'b0, data: BEAT_DATA_W'(PKT_VIDEO)};
        end
      end
      S_CAPTURE: begin
        if (pixel) begin
          wr = 1'b1;
          if (ovf) begin
            wbeat.eop = 1'b1;
            ovf_inc = 1'b1;
            state_d = S_DROP;
          end else begin
            hold_d = '{sop: 1'b0, eop: 1'b0, data: BEAT_DATA_W'(d_q)};
          end
        end else if (fval_fall) begin
          wr = 1'b1;
          wbeat.eop = 1'b1;
          frame_inc = 1'b1;
          dims_upd = 1'b1;
`ifdef CAM_CTRL_PKT_EN
          state_d = S_CTRL;
          idx_d = '0;
`else
          state_d = S_IDLE;
`endif
        end
      end
      S_DROP: begin
        if (!fval_q) state_d = S_IDLE;
      end
`ifdef CAM_CTRL_PKT_EN
      S_CTRL: begin
        skip_inc = fval_rise;
        if (space) begin
          wr = 1'b1;
          wbeat = '{sop: idx_q == 4'd0, eop: idx_q == 4'd9, data: BEAT_DATA_W'(nib)};
          idx_d = idx_q + 1'b1;
          if (idx_q == 4'd9) state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      d_q <= '0;
      // fval history resets high so a frame already running at release never looks like a rise
      fval_q <= 1'b1;
      fval_p_q <= 1'b1;
      lval_q <= 1'b0;
      lval_p_q <= 1'b0;
      state_q <= S_IDLE;
      hold_q <= '0;
      frame_q <= '0;
      ovf_q <= '0;
      lw_q <= '0;
      lh_q <= '0;
      cw_q <= '0;
      ch_q <= '0;
`ifdef CAM_CTRL_PKT_EN
      idx_q <= '0;
      skip_q <= '0;
`endif
    end else begin
      d_q <= cam_d;
      fval_q <= cam_fval;
      fval_p_q <= fval_q;
      lval_q <= cam_lval;
      lval_p_q <= lval_q;
      state_q <= state_d;
      hold_q <= hold_d;
      if (frame_inc) frame_q <= sat_inc(frame_q);
      if (ovf_inc) ovf_q <= sat_inc(ovf_q);
      if (dims_upd) begin
        lw_q <= cw_q;
        lh_q <= ch_q;
      end
      if (state_q == S_IDLE) begin
        cw_q <= '0;
        ch_q <= '0;
      end else if (state_q == S_CAPTURE) begin
        if (lval_rise) ch_q <= sat_inc(ch_q);
        if (pixel) cw_q <= lval_rise ? CNT_W'(1) : sat_inc(cw_q);
      end
`ifdef CAM_CTRL_PKT_EN
      idx_q <= idx_d;
      if (skip_inc) skip_q <= sat_inc(skip_q);
`endif
    end
  end
  cam_cap_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .wr_i(wr),
    .wd_i(wbeat),
    .rd_ready_i(st_ready),
    .valid_o(st_valid),
    .rd_o(rd_beat),
    .cnt_o(fifo_cnt)
  );
  assign st_data = DATA_W'(rd_beat.data);
  assign st_sop = rd_beat.sop;
  assign st_eop = rd_beat.eop;
  assign frame_cnt = frame_q;
  assign ovf_cnt = ovf_q;
  assign last_width = lw_q;
  assign last_height = lh_q;
  assign busy = state_q != S_IDLE;
endmodule
